movavg_fltr_gen: RTL and testbench
==================================

# movavg_fltr_gen

Parametrised moving-average filter: next generation of the fixed 2/4/8/16 filter in the peak-detect front end. It sits between the pixel source and the peak detector. It supports a generic data width and a power-of-two window up to 2^LOG2_MAXWIN, selectable at runtime, with rounding, two start-up fill modes and configurable restart-on-gap. Throughput is one sample per clock; output is registered with fixed one-cycle latency.

## Interface
- DATAWIDTH, 12: sample width.
- LOG2_MAXWIN, 4: log2 of maximum window (depth of history buffer = 2^LOG2_MAXWIN).
- GAP_RESTART, 1: 1 = a cycle with vald_din=0 mid-stream restarts the stream; 0 = gaps hold state.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_act  in  1  synchronous clear; returns filter to IDLE.
- movavg_en  in  1  1 = filter, 0 = registered bypass.
- vald_din  in  1  input sample valid.
- data_in  in  DATAWIDTH  input sample, unsigned.
- win_log2  in  $clog2(LOG2_MAXWIN+1)  window N = 2^win_log2; values > LOG2_MAXWIN clamp to LOG2_MAXWIN.
- round_en  in  1  1 = round half up, 0 = truncate.
- fill_mode  in  1  0 = replicate first sample, 1 = zero-fill and suppress output until window full.
- data_out  out  DATAWIDTH  averaged (or bypassed) sample.
- valid_out  out  1  data_out valid.
- win_full  out  1  high while state is RUN.

## Operation
- Accepted sample: vald_din=1 & movavg_en=1 & start_act=0.
- State
  - IDLE: entered on reset, start_act, movavg_en=0, a change of win_log2 versus the registered win_q, or (GAP_RESTART=1) vald_din=0 in FILL/RUN.
  - FILL: zero-fill start-up, window not yet full.
  - RUN: window full.
- History: circular buffer of 2^LOG2_MAXWIN entries and write pointer wptr, which wraps. The oldest sample is buf[wptr-N] (mod depth); it is read before the write in the same cycle, so N=max reads the slot being overwritten.
- Accumulator acc: DATAWIDTH+LOG2_MAXWIN bits, unsigned, never overflows.
- First accepted sample in IDLE:
  - win_q, fill_mode and N are latched here; fill_mode changes mid-stream are ignored.
  - fill_mode=0: every buffer entry <= data_in; acc <= data_in<<k; go to RUN.
  - fill_mode=1: buffer zeroed; acc <= data_in; cnt <= 1; go to FILL, or to RUN if N=1.
- FILL/RUN, each accepted sample:
  - acc <= acc - oldest + data_in.
  - FILL increments cnt and goes to RUN when cnt reaches N.
- Output
  - avg = (acc + (round_en ? N>>1 : 0)) >> k. For N=1, avg = data_in.
  - Result is at most 2^DATAWIDTH-1, so no saturation logic is needed.
- valid_out, one cycle after an accepted sample:
  - fill_mode=0: valid for every sample.
  - fill_mode=1: valid only for samples that leave the state in RUN.
  - Suppressed samples drive data_out=0.
- Bypass (movavg_en=0): data_out <= data_in and valid_out <= vald_din, registered. State is forced to IDLE.
- Simultaneous events, in priority order: reset > start_act > movavg_en=0 > win_log2 change > accept.
  - A win_log2 change coincident with a valid sample restarts, and that sample becomes the first sample of the new stream with the new N.

## Timing
- Reset values: data_out=0, valid_out=0, win_full=0, acc=0, buffer=0, wptr=0, cnt=0, state=IDLE.
- Latency: data_in/vald_din at edge t gives data_out/valid_out at edge t+1, in all modes including bypass.
- start_act at edge t: valid_out=0 at t+1, even if vald_din=1 at t.
- Gap with GAP_RESTART=1: valid_out=0 at t+1; the next accepted sample is a first sample.
- Gap with GAP_RESTART=0: acc, buffer, cnt and wptr hold.
- win_full: updates with the same latency as valid_out. It is 1 on the output cycle of the sample that fills the window.

## Test plan
- fill_mode=0, N=4, truncate, samples 100,200,300,400,500 back-to-back -> data_out 100,125,175,250,350, valid every cycle; win_full=1 from first output.
- fill_mode=1, N=4, same stream -> valid_out only on 4th/5th outputs, 250 and 350, data_out=0 otherwise; win_full rises with 250.
- N=2, samples 1,2, fill_mode=0 -> round_en=1 gives 1,2; round_en=0 gives 1,1.
- N=16, 20 samples of 4095, round_en=1 -> data_out 4095 every cycle, no wrap.
- N=4 RUN stream, then each of:
  - one-cycle gap (GAP_RESTART=1), then sample 800 -> output 800 (fill_mode=0).
  - win_log2 change 2->1 on a valid sample 600 -> output 600, new N=2.
  - start_act with vald_din=1 -> valid_out=0 next cycle.
  - reset asserted mid-stream -> all outputs 0 immediately.
- movavg_en=0 with stream 7,9,11 -> data_out 7,9,11 one cycle later, valid_out mirrors vald_din delayed one cycle. Re-enable -> first sample restarts the filter.

Source files
------------

// File: rtl/movavg_fltr_gen.sv
// Moving-average filter with a runtime-selectable power-of-two window, optional rounding,
// replicate or zero-fill start-up, and a registered bypass path. One sample per clock, one-cycle latency.
//
// state | meaning
// IDLE  | no stream in progress; the next accepted sample starts one
// FILL  | zero-fill start-up, fewer than N samples seen
// RUN   | window full
module movavg_fltr_gen #(
    parameter int DATAWIDTH   = 12,
    parameter int LOG2_MAXWIN = 4,
    parameter int GAP_RESTART = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_act,
    input  logic                               movavg_en,
    input  logic                               vald_din,
    input  logic [DATAWIDTH-1:0]               data_in,
    input  logic [$clog2(LOG2_MAXWIN+1)-1:0]   win_log2,
    input  logic                               round_en,
    input  logic                               fill_mode,
    output logic [DATAWIDTH-1:0]               data_out,
    output logic                               valid_out,
    output logic                               win_full
);
    localparam int WW    = $clog2(LOG2_MAXWIN + 1);
    localparam int AW    = DATAWIDTH + LOG2_MAXWIN;
    localparam int CW    = LOG2_MAXWIN + 1;
    localparam int DEPTH = 1 << LOG2_MAXWIN;
    localparam logic [WW-1:0] WMAX = WW'(LOG2_MAXWIN);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                   state_q, state_d;
    logic [WW-1:0]            win_q, win_d;
    logic                     fill_q, fill_d;
    logic [AW-1:0]            acc_q, acc_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [LOG2_MAXWIN-1:0]   wptr_q, wptr_d;
    logic [DATAWIDTH-1:0]     hist_q [DEPTH];
    logic [DATAWIDTH-1:0]     dout_q, dout_d;
    logic                     vout_q, vout_d;
    logic                     wfull_q;

    logic [WW-1:0]            win_eff;
    logic [CW-1:0]            n_w;
    logic [LOG2_MAXWIN-1:0]   old_idx;
    logic [DATAWIDTH-1:0]     oldest;
    logic                     active, win_chg, accepted, first, fm, vld_res;
    logic                     wr_en, fill_all;
    logic [DATAWIDTH-1:0]     fill_val;
    logic [AW-1:0]            acc_sum;

    always_comb begin
        win_eff = (win_log2 > WMAX) ? WMAX : win_log2;
        n_w     = CW'(1) << win_eff;
        old_idx = wptr_q - n_w[LOG2_MAXWIN-1:0];
        oldest  = hist_q[old_idx];
        active  = (state_q != IDLE);
        win_chg = active && (win_eff != win_q);

        state_d  = state_q;
        win_d    = win_q;
        fill_d   = fill_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wptr_d   = wptr_q;
        dout_d   = '0;
        vout_d   = 1'b0;
        wr_en    = 1'b0;
        fill_all = 1'b0;
        fill_val = '0;
        accepted = 1'b0;
        first    = 1'b0;
        fm       = fill_q;
        vld_res  = 1'b0;
        acc_sum  = '0;

        if (start_act) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            wptr_d  = '0;
        end else if (!movavg_en) begin
            state_d = IDLE;
            dout_d  = data_in;
            vout_d  = vald_din;
        end else if (vald_din && (!active || win_chg)) begin
            // a window change on a valid sample restarts with this sample as the first one
            accepted = 1'b1;
            first    = 1'b1;
            fm       = fill_mode;
            win_d    = win_eff;
            fill_d   = fill_mode;
            fill_all = 1'b1;
            fill_val = fill_mode ? '0 : data_in;
            wr_en    = 1'b1;
            wptr_d   = wptr_q + LOG2_MAXWIN'(1);
            if (!fill_mode) begin
                acc_d   = AW'(data_in) << win_eff;
                state_d = RUN;
            end else begin
                acc_d   = AW'(data_in);
                cnt_d   = CW'(1);
                state_d = (win_eff == '0) ? RUN : FILL;
            end
        end else if (win_chg) begin
            state_d = IDLE;
        end else if (!vald_din) begin
            if (GAP_RESTART != 0 && active) state_d = IDLE;
        end else begin
            accepted = 1'b1;
            wr_en    = 1'b1;
            wptr_d   = wptr_q + LOG2_MAXWIN'(1);
            acc_d    = acc_q - AW'(oldest) + AW'(data_in);
            if (state_q == FILL) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == n_w) state_d = RUN;
            end
        end

        if (accepted) begin
            acc_sum = acc_d + (round_en ? AW'(n_w >> 1) : AW'(0));
            vld_res = !fm || (state_d == RUN);
            vout_d  = vld_res;
            dout_d  = vld_res ? DATAWIDTH'(acc_sum >> win_eff) : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            fill_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
            wfull_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            wfull_q <= (state_d == RUN);
            if (fill_all) begin
                for (int i = 0; i < DEPTH; i++) hist_q[i] <= fill_val;
            end
            if (wr_en) hist_q[wptr_q] <= data_in;
        end
    end

    assign data_out  = dout_q;
    assign valid_out = vout_q;
    assign win_full  = wfull_q;
endmodule

// File: tb/tb_movavg_fltr_gen.sv
// Directed bench for movavg_fltr_gen: a vector table of per-cycle stimulus with hand-computed
// outputs, followed by a long N=16 run and an asynchronous reset in mid-stream.
module tb_movavg_fltr_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_act;
    logic        movavg_en;
    logic        vald_din;
    logic [11:0] data_in;
    logic [2:0]  win_log2;
    logic        round_en;
    logic        fill_mode;
    logic [11:0] data_out;
    logic        valid_out;
    logic        win_full;

    int n_checks = 0;
    int n_fail   = 0;

    movavg_fltr_gen #(.DATAWIDTH(12), .LOG2_MAXWIN(4), .GAP_RESTART(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_act (start_act),
        .movavg_en (movavg_en),
        .vald_din  (vald_din),
        .data_in   (data_in),
        .win_log2  (win_log2),
        .round_en  (round_en),
        .fill_mode (fill_mode),
        .data_out  (data_out),
        .valid_out (valid_out),
        .win_full  (win_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        en;
        logic        vld;
        logic [11:0] din;
        logic [2:0]  win;
        logic        rnd;
        logic        fm;
        logic [11:0] e_dout;
        logic        e_vout;
        logic        e_wfull;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic en, input logic vld, input int din,
                                input int win, input logic rnd, input logic fm,
                                input int e_dout, input logic e_vout, input logic e_wfull);
        vec_t v;
        v.st = st; v.en = en; v.vld = vld; v.din = 12'(din); v.win = 3'(win);
        v.rnd = rnd; v.fm = fm; v.e_dout = 12'(e_dout); v.e_vout = e_vout; v.e_wfull = e_wfull;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic st, input logic en, input logic vld, input logic [11:0] din,
                         input logic [2:0] win, input logic rnd, input logic fm);
        start_act = st; movavg_en = en; vald_din = vld; data_in = din;
        win_log2 = win; round_en = rnd; fill_mode = fm;
    endtask

    task automatic check(input string name, input logic [11:0] e_dout, input logic e_vout,
                         input logic e_wfull);
        n_checks++;
        if (data_out !== e_dout || valid_out !== e_vout || win_full !== e_wfull) begin
            n_fail++;
            $display("FAIL %s: got data_out=%0d valid_out=%b win_full=%b, want data_out=%0d valid_out=%b win_full=%b",
                     name, data_out, valid_out, win_full, e_dout, e_vout, e_wfull);
        end
    endtask

    initial begin
        // st en vld din win rnd fm | dout vout wfull
        // N=4 replicate, truncate
        add(0,1,1,100,2,0,0, 100,1,1);
        add(0,1,1,200,2,0,0, 125,1,1);
        add(0,1,1,300,2,0,0, 175,1,1);
        add(0,1,1,400,2,0,0, 250,1,1);
        add(0,1,1,500,2,0,0, 350,1,1);
        add(1,1,1,999,2,0,0,   0,0,0);
        // N=4 zero-fill
        add(0,1,1,100,2,0,1,   0,0,0);
        add(0,1,1,200,2,0,1,   0,0,0);
        add(0,1,1,300,2,0,1,   0,0,0);
        add(0,1,1,400,2,0,1, 250,1,1);
        add(0,1,1,500,2,0,1, 350,1,1);
        add(1,1,0,  0,2,0,0,   0,0,0);
        // N=2 rounding vs truncation
        add(0,1,1,  1,1,1,0,   1,1,1);
        add(0,1,1,  2,1,1,0,   2,1,1);
        add(1,1,0,  0,1,0,0,   0,0,0);
        add(0,1,1,  1,1,0,0,   1,1,1);
        add(0,1,1,  2,1,0,0,   1,1,1);
        add(1,1,0,  0,2,0,0,   0,0,0);
        // N=4 run, gap restart, window change, start_act with valid
        add(0,1,1,100,2,0,0, 100,1,1);
        add(0,1,1,200,2,0,0, 125,1,1);
        add(0,1,1,300,2,0,0, 175,1,1);
        add(0,1,1,400,2,0,0, 250,1,1);
        add(0,1,0,  0,2,0,0,   0,0,0);
        add(0,1,1,800,2,0,0, 800,1,1);
        add(0,1,1,600,1,0,0, 600,1,1);
        add(0,1,1,200,1,0,0, 400,1,1);
        add(1,1,1,300,1,0,0,   0,0,0);
        // bypass
        add(0,0,1,  7,2,0,0,   7,1,0);
        add(0,0,1,  9,2,0,0,   9,1,0);
        add(0,0,1, 11,2,0,0,  11,1,0);
        add(0,0,0, 13,2,0,0,  13,0,0);
        // re-enable restarts the filter
        add(0,1,1, 40,2,0,0,  40,1,1);
        add(0,1,1, 80,2,0,0,  50,1,1);
        // out-of-range window clamps to N=16
        add(0,1,1,160,7,0,0, 160,1,1);
        add(0,1,1,  0,7,0,0, 150,1,1);
        // N=1 zero-fill goes straight to RUN
        add(0,1,1, 55,0,0,1,  55,1,1);
        add(0,1,1, 66,0,0,1,  66,1,1);

        drive(0,0,0,0,0,0,0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_state", 12'd0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].st, vecs[i].en, vecs[i].vld, vecs[i].din, vecs[i].win,
                  vecs[i].rnd, vecs[i].fm);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_vout, vecs[i].e_wfull);
        end

        // N=16, full-scale input with rounding must not wrap
        @(negedge clk);
        drive(1,1,0,0,4,1,0);
        @(posedge clk);
        #1;
        check("start_before_n16", 12'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(0,1,1,12'd4095,4,1,0);
            @(posedge clk);
            #1;
            check($sformatf("n16_full_scale_%0d", i), 12'd4095, 1'b1, 1'b1);
        end

        // asynchronous reset mid-stream clears outputs without waiting for a clock edge
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 12'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(0,1,1,12'd321,2,0,0);
        @(posedge clk);
        #1;
        check("after_reset_first", 12'd321, 1'b1, 1'b1);
        @(negedge clk);
        drive(0,1,1,12'd1,2,0,0);
        @(posedge clk);
        #1;
        check("after_reset_second", 12'd241, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
